// File: rtl/mem_init_engine.sv
// Memory-initialisation engine: sweeps a single-port RAM from address 0 to DEPTH-1,
// one registered write per clock, with a start/busy/done handshake and abort.
module mem_init_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] data_o,
  output logic              wren_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    M_IDENT = 2'd0,
    M_CONST = 2'd1,
    M_DESC  = 2'd2,
    M_XOR   = 2'd3
  } mode_e;

  // Terminal count; equals all ones when DEPTH fills the whole address space.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [DATA_W-1:0] pattern(input mode_e                m,
                                                input logic [ADDR_W-1:0]  a,
                                                input logic [DATA_W-1:0]  fv);
    int unsigned idx;
    idx = 32'(a);
    case (m)
      M_IDENT: pattern = DATA_W'(idx);
      M_CONST: pattern = fv;
      M_DESC:  pattern = DATA_W'(32'(DEPTH - 1) - idx);
      default: pattern = DATA_W'(idx) ^ fv;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q,   cnt_d;
  mode_e               mode_q,  mode_d;
  logic [DATA_W-1:0]   fv_q,    fv_d;
  logic [DATA_W-1:0]   data_q,  data_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= M_IDENT;
      fv_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fv_q    <= fv_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fv_d    = fv_q;
    case (state_q)
      S_FILL: begin
        if (abort_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        // Abort has priority over a simultaneous start.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d = S_FILL;
          cnt_d   = '0;
          mode_d  = mode_e'(mode_i);
          fv_d    = fill_value_i;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Write data is produced one cycle ahead so it lines up with the registered address.
    data_d = (state_d == S_FILL) ? pattern(mode_d, cnt_d, fv_d) : '0;
  end

  assign address_o = cnt_q;
  assign data_o    = data_q;
  assign wren_o    = (state_q == S_FILL);
  assign busy_o    = (state_q == S_FILL);
  assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_init_engine.sv
// Bench for mem_init_engine: three parameterisations share one stimulus stream and
// are compared every cycle against a write-sequence model, plus pinned literal values.
module tb_mem_init_engine;

  logic        clock_i = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i;
  logic [1:0]  mode_i;
  logic [11:0] fv_i;

  logic [7:0]  addr0, data0;
  logic [3:0]  addr1, addr2;
  logic [11:0] data1;
  logic [7:0]  data2;
  logic        wren0, busy0, done0;
  logic        wren1, busy1, done1;
  logic        wren2, busy2, done2;

  int checks   = 0;
  int failures = 0;

  always #5 clock_i = ~clock_i;

  mem_init_engine u0 (
    .clock_i(clock_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .fill_value_i(fv_i[7:0]),
    .address_o(addr0), .data_o(data0), .wren_o(wren0), .busy_o(busy0), .done_o(done0));

  mem_init_engine #(.ADDR_W(4), .DATA_W(12), .DEPTH(16)) u1 (
    .clock_i(clock_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .fill_value_i(fv_i),
    .address_o(addr1), .data_o(data1), .wren_o(wren1), .busy_o(busy1), .done_o(done1));

  mem_init_engine #(.ADDR_W(4), .DATA_W(8), .DEPTH(1)) u2 (
    .clock_i(clock_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .fill_value_i(fv_i[7:0]),
    .address_o(addr2), .data_o(data2), .wren_o(wren2), .busy_o(busy2), .done_o(done2));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: each instance is idle, writing word `pos` of its sweep, or finished.
  localparam int PH_IDLE = 0, PH_FILL = 1, PH_DONE = 2;
  int depth_m[3] = '{256, 16, 1};
  int mask_m[3]  = '{'hFF, 'hFFF, 'hFF};
  int ph[3], pos[3], lm[3], lfv[3];
  int s_rst, s_start, s_abort, s_mode, s_fv;
  int act_addr[3], act_data[3], act_wren[3], act_busy[3], act_done[3];

  function automatic int expected_data(input int i);
    int v;
    case (lm[i])
      0:       v = pos[i];
      1:       v = lfv[i];
      2:       v = depth_m[i] - 1 - pos[i];
      default: v = pos[i] ^ lfv[i];
    endcase
    return v & mask_m[i];
  endfunction

  always @(posedge clock_i) begin
    s_rst   = int'(rst_ni);
    s_start = int'(start_i);
    s_abort = int'(abort_i);
    s_mode  = int'(mode_i);
    s_fv    = int'(fv_i);
    #1;
    act_addr = '{int'(addr0), int'(addr1), int'(addr2)};
    act_data = '{int'(data0), int'(data1), int'(data2)};
    act_wren = '{int'(wren0), int'(wren1), int'(wren2)};
    act_busy = '{int'(busy0), int'(busy1), int'(busy2)};
    act_done = '{int'(done0), int'(done1), int'(done2)};
    for (int i = 0; i < 3; i++) begin
      if (s_rst == 0) begin
        ph[i] = PH_IDLE; pos[i] = 0; lm[i] = 0; lfv[i] = 0;
      end else if (ph[i] == PH_FILL) begin
        if (s_abort != 0)                 ph[i] = PH_IDLE;
        else if (pos[i] == depth_m[i] - 1) ph[i] = PH_DONE;
        else                               pos[i]++;
      end else if (s_abort != 0) begin
        ph[i] = PH_IDLE;
      end else if (s_start != 0) begin
        ph[i] = PH_FILL; pos[i] = 0; lm[i] = s_mode; lfv[i] = s_fv & mask_m[i];
      end
      check($sformatf("u%0d_wren", i), act_wren[i], int'(ph[i] == PH_FILL));
      check($sformatf("u%0d_busy", i), act_busy[i], int'(ph[i] == PH_FILL));
      check($sformatf("u%0d_done", i), act_done[i], int'(ph[i] == PH_DONE));
      if (ph[i] == PH_FILL) begin
        check($sformatf("u%0d_addr", i), act_addr[i], pos[i]);
        check($sformatf("u%0d_data", i), act_data[i], expected_data(i));
      end
    end
  end

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst_ni = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'd0; fv_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_addr", int'(addr0), 0);
    check("rst_data", int'(data0), 0);
    check("rst_wren", int'(wren0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    cycles(2);
    rst_ni = 1'b1;
    cycles(2);

    // Identity fill on every instance.
    mode_i = 2'd0; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("m0_first_wren", int'(wren0), 1);
    check("m0_first_addr", int'(addr0), 0);
    check("d1_single_wren", int'(wren2), 1);
    cycles(15);
    check("w12_last_addr", int'(addr1), 'hF);
    check("w12_last_data", int'(data1), 'h00F);
    check("d1_done", int'(done2), 1);
    cycles(240);
    check("m0_last_addr", int'(addr0), 'hFF);
    check("m0_last_data", int'(data0), 'hFF);
    cyc();
    check("m0_done", int'(done0), 1);
    check("m0_wren_low", int'(wren0), 0);

    // Constant fill on the 16-deep instance with start pulses during the sweep.
    mode_i = 2'd1; fv_i = 12'h0A5; start_i = 1'b1;
    cyc();
    start_i = 1'b0; mode_i = 2'd2; fv_i = '0;
    check("m1_first_data", int'(data1), 'h0A5);
    for (int i = 0; i < 15; i++) begin
      start_i = 1'($urandom_range(0, 1));
      cyc();
    end
    start_i = 1'b0;
    check("m1_last_addr", int'(addr1), 'hF);
    check("m1_last_data", int'(data1), 'h0A5);
    cyc();
    check("m1_done17", int'(done1), 1);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    check("abort_idle_done", int'(done1), 0);
    check("abort_idle_busy", int'(busy0), 0);

    // Descending then back-to-back xor fill on the 256-deep instance.
    mode_i = 2'd2; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("m2_first_data", int'(data0), 'hFF);
    cycles(255);
    check("m2_last_data", int'(data0), 'h00);
    cyc();
    check("m2_done", int'(done0), 1);
    mode_i = 2'd3; fv_i = 12'h00F; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("b2b_done_low", int'(done0), 0);
    check("b2b_addr", int'(addr0), 0);
    check("m3_first_data", int'(data0), 'h0F);
    cycles(255);
    check("m3_last_data", int'(data0), 'hF0);
    cyc();
    check("m3_done", int'(done0), 1);

    // Start together with abort in DONE: abort wins.
    start_i = 1'b1; abort_i = 1'b1;
    cyc();
    start_i = 1'b0; abort_i = 1'b0;
    check("sa_done", int'(done0), 0);
    check("sa_wren", int'(wren0), 0);
    cycles(3);

    // Abort while address 37 is being written.
    mode_i = 2'd0; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cycles(37);
    check("ab_addr37", int'(addr0), 37);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    check("ab_wren", int'(wren0), 0);
    check("ab_busy", int'(busy0), 0);
    check("ab_done", int'(done0), 0);
    cycles(3);

    // Asynchronous reset mid-fill at address 100.
    mode_i = 2'd1; fv_i = 12'h03C; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cycles(100);
    check("rs_addr100", int'(addr0), 100);
    #2 rst_ni = 1'b0;
    #1;
    check("rs_addr", int'(addr0), 0);
    check("rs_data", int'(data0), 0);
    check("rs_wren", int'(wren0), 0);
    check("rs_done1", int'(done1), 0);
    cycles(2);
    rst_ni = 1'b1;
    cycles(4);
    check("rs_no_write", int'(wren0), 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      start_i = 1'($urandom_range(0, 7) == 0);
      abort_i = 1'($urandom_range(0, 511) == 0);
      mode_i  = 2'($urandom_range(0, 3));
      fv_i    = 12'($urandom);
      rst_ni  = 1'($urandom_range(0, 999) != 0);
      cyc();
    end
    rst_ni = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
